// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_pkg
// Description : Shared constants and types for the rotated-immediate encoder.
//               The operand format is {rot[3:0], imm8[7:0]}, and its value is
//               ROR(imm8, ROT_STEP*rot).
// Revision    : 1.0 - initial release
// ============================================================================
package imm_encoder_pkg;

  // Bit positions per rotation count. This must match the decoder.
  localparam int ROT_STEP = 2;
  localparam int IMM_W    = 8;
  localparam int ROT_W    = 4;

  // Encoded operand. The packed order gives enc = {rot, imm8}.
  typedef struct packed {
    logic [ROT_W-1:0] rot;
    logic [IMM_W-1:0] imm8;
  } imm_enc_t;

  // Encoder states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SEARCH = ST_SEARCH,
    DONE   = ST_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/imm_rotl.sv
`default_nettype none
// ============================================================================
// Module      : imm_rotl
// Description : Combinational rotate-left of a DATA_W-bit word by ROT_STEP*r.
//               It forms the trial word that the encoder tests on each cycle.
// Ports       : data_i  - word to rotate
//               rot_i   - rotation count r (0..15)
//               data_o  - ROL(data_i, ROT_STEP*r)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_rotl #(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [3:0]        rot_i,
  output logic [DATA_W-1:0] data_o
);
  import imm_encoder_pkg::*;

  localparam int SH_W = $clog2(2 * DATA_W);

  logic [SH_W-1:0]     w_shamt;
  logic [SH_W-1:0]     w_rsh;
  logic [2*DATA_W-1:0] w_dbl;

  assign w_shamt = SH_W'(ROT_STEP * int'(rot_i));
  // To rotate left by s, shift the doubled word right by (DATA_W - s) and keep
  // the low half. With s = 0 the shift is DATA_W, which returns data_i.
  assign w_rsh   = SH_W'(DATA_W) - w_shamt;
  assign w_dbl   = {data_i, data_i};
  assign data_o  = DATA_W'(w_dbl >> w_rsh);

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Iterative encoder for the 12-bit rotated-immediate format.
//               It tests one rotation per cycle, in ascending order, so the
//               smallest rot that represents the value is the one returned.
// Ports       : clk, reset          - clock and sync active-high reset
//               in_valid/in_ready   - request handshake (value)
//               out_valid/out_ready - result handshake
//               found               - 1 = encodable, 0 = unencodable
//               rot, imm8, enc      - result fields, enc = {rot, imm8}
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder #(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              found,
  output logic [3:0]        rot,
  output logic [7:0]        imm8,
  output logic [11:0]       enc
);
  import imm_encoder_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [3:0]        r_q,     r_d;
  logic              found_q, found_d;
  imm_enc_t          res_q,   res_d;

  logic [DATA_W-1:0] w_trial;
  logic              w_hit;

  imm_rotl #(
    .DATA_W   (DATA_W),
    .ROT_STEP (ROT_STEP)
  ) u_rotl (
    .data_i (value_q),
    .rot_i  (r_q),
    .data_o (w_trial)
  );

  // The value is representable at rotation r if rotating it back leaves only
  // the low byte populated.
  assign w_hit = (w_trial[DATA_W-1:IMM_W] == '0);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    r_d     = r_q;
    found_d = found_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        // The previous result stays on the outputs until a new search ends.
        if (in_valid) begin
          value_d = value;
          r_d     = 4'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (w_hit) begin
          found_d    = 1'b1;
          res_d.rot  = r_q;
          res_d.imm8 = w_trial[IMM_W-1:0];
          state_d    = DONE;
        end else if (r_q == 4'hF) begin
          found_d    = 1'b0;
          res_d.rot  = 4'd0;
          res_d.imm8 = 8'd0;
          state_d    = DONE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      r_q     <= 4'd0;
      found_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      r_q     <= r_d;
      found_q <= found_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign found     = found_q;
  assign rot       = res_q.rot;
  assign imm8      = res_q.imm8;
  assign enc       = res_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder. The reference model
//               encodes by searching the rotations and confirming each
//               candidate through an arithmetic decode, ROR(imm8, 2*rot).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic        found;
  logic [3:0]  rot;
  logic [7:0]  imm8;
  logic [11:0] enc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_encoder #(
    .DATA_W   (32),
    .ROT_STEP (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .found     (found),
    .rot       (rot),
    .imm8      (imm8),
    .enc       (enc)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_ror(input logic [31:0] x, input int sh);
    int s;
    s = sh % 32;
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] m_decode(input logic [11:0] e);
    return m_ror({24'h0, e[7:0]}, 2 * int'(e[11:8]));
  endfunction

  // Returns the smallest rotation whose decode reproduces v.
  function automatic void m_encode(input logic [31:0] v, output logic f,
                                   output logic [11:0] e);
    f = 1'b0;
    e = 12'h000;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] back;
      logic [3:0]  kr;
      kr   = k[3:0];
      back = m_ror(v, 32 - 2 * k);
      if (m_decode({kr, back[7:0]}) == v) begin
        f = 1'b1;
        e = {kr, back[7:0]};
        return;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge. It returns just after the falling edge
  // where out_valid is first seen. out_ready stays high, so the result is
  // consumed on the next rising edge.
  task automatic do_req(input logic [31:0] v, output logic f, output logic [3:0] r,
                        output logic [7:0] i8, output logic [11:0] e,
                        output int lat, output bit tmo);
    int k;
    k   = 0;
    tmo = 1'b0;
    lat = 0;
    f = 1'b0; r = 4'h0; i8 = 8'h00; e = 12'h000;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      tmo = 1'b1;
      return;
    end
    in_valid  = 1'b1;
    value     = v;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    value    = $urandom;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tmo = !out_valid;
    f = found; r = rot; i8 = imm8; e = enc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    value     = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if ({found, rot, imm8, enc} !== 25'h0) begin
      n_fail++; $display("FAIL reset_outputs: got found=%b enc=%h rot=%h imm8=%h expected all 0",
                         found, enc, rot, imm8);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] tv [5];
    logic        tf [5];
    logic [11:0] te [5];
    int          tl [5];
    logic f; logic [3:0] r; logic [7:0] i8; logic [11:0] e; int lat; bit tmo;
    tv = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h00000104, 32'h00000101};
    tf = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    te = '{12'h0FF, 12'h4FF, 12'h2FF, 12'hF41, 12'h000};
    tl = '{1, 5, 3, 16, 16};
    for (int i = 0; i < 5; i++) begin
      do_req(tv[i], f, r, i8, e, lat, tmo);
      n_checks++;
      if (tmo) begin
        n_fail++; $display("FAIL directed_timeout v=%h: got no out_valid expected out_valid", tv[i]);
      end
      n_checks++;
      if (f !== tf[i]) begin
        n_fail++; $display("FAIL directed_found v=%h: got %b expected %b", tv[i], f, tf[i]);
      end
      n_checks++;
      if (e !== te[i]) begin
        n_fail++; $display("FAIL directed_enc v=%h: got %h expected %h", tv[i], e, te[i]);
      end
      n_checks++;
      if ({r, i8} !== te[i]) begin
        n_fail++; $display("FAIL directed_fields v=%h: got rot=%h imm8=%h expected %h",
                           tv[i], r, i8, te[i]);
      end
      n_checks++;
      if (lat != tl[i]) begin
        n_fail++; $display("FAIL directed_latency v=%h: got %0d expected %0d", tv[i], lat, tl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_valid  = 1'b1;
    value     = 32'hFF000000;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != 5) begin
      n_fail++; $display("FAIL bp_latency: got %0d expected 5", k);
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_handshake c=%0d: got out_valid=%b in_ready=%b expected 1/0",
                           c, out_valid, in_ready);
      end
      n_checks++;
      if (found !== 1'b1 || enc !== 12'h4FF || rot !== 4'h4 || imm8 !== 8'hFF) begin
        n_fail++; $display("FAIL bp_stable c=%0d: got found=%b enc=%h expected 1/4ff", c, found, enc);
      end
      in_valid = (c % 2 == 0);
      value    = 32'h000000FF;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_consume: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (enc !== 12'h4FF) begin
      n_fail++; $display("FAIL bp_hold: got %h expected 4ff", enc);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ignored_req: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic f; logic [3:0] r; logic [7:0] i8; logic [11:0] e; int lat; bit tmo;
    int k;
    do_req(32'hF000000F, f, r, i8, e, lat, tmo);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    value    = 32'h00000104;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_state: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (found !== 1'b0 || rot !== 4'h0 || imm8 !== 8'h00 || enc !== 12'h000) begin
      n_fail++; $display("FAIL abort_outputs: got found=%b enc=%h expected 0/000", found, enc);
    end
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    n_checks++;
    if (k != 0) begin
      n_fail++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", k);
    end
    do_req(32'h0, f, r, i8, e, lat, tmo);
    n_checks++;
    if (tmo || f !== 1'b1 || e !== 12'h000 || lat != 1) begin
      n_fail++; $display("FAIL abort_next_req: got tmo=%b found=%b enc=%h lat=%0d expected 0/1/000/1",
                         tmo, f, e, lat);
    end
  endtask

  task automatic test_random();
    logic f; logic [3:0] r; logic [7:0] i8; logic [11:0] e; int lat; bit tmo;
    logic [31:0] v;
    logic        xf;
    logic [11:0] xe;
    int          xl;
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) v = $urandom;
      else            v = m_decode(12'($urandom_range(0, 4095)));
      m_encode(v, xf, xe);
      xl = xf ? int'(xe[11:8]) + 1 : 16;
      do_req(v, f, r, i8, e, lat, tmo);
      n_checks++;
      if (tmo || f !== xf || e !== xe || {r, i8} !== xe) begin
        n_fail++; $display("FAIL random_enc v=%h: got tmo=%b found=%b enc=%h expected found=%b enc=%h",
                           v, tmo, f, e, xf, xe);
      end
      n_checks++;
      if (lat != xl) begin
        n_fail++; $display("FAIL random_latency v=%h: got %0d expected %0d", v, lat, xl);
      end
    end
  endtask

  task automatic test_sweep();
    logic f; logic [3:0] r; logic [7:0] i8; logic [11:0] e; int lat; bit tmo;
    logic [31:0] v;
    logic        xf;
    logic [11:0] xe;
    int          off;
    logic [11:0] src;
    off = $urandom_range(0, 4095);
    for (int i = 0; i < 4096; i++) begin
      src = 12'((i + off) % 4096);
      v   = m_decode(src);
      m_encode(v, xf, xe);
      do_req(v, f, r, i8, e, lat, tmo);
      n_checks++;
      if (tmo || f !== 1'b1) begin
        n_fail++; $display("FAIL sweep_found src=%h v=%h: got tmo=%b found=%b expected 1", src, v, tmo, f);
      end
      n_checks++;
      if (m_decode(e) !== v) begin
        n_fail++; $display("FAIL sweep_roundtrip src=%h: got enc=%h decodes %h expected %h",
                           src, e, m_decode(e), v);
      end
      n_checks++;
      if (e !== xe || lat != int'(xe[11:8]) + 1) begin
        n_fail++; $display("FAIL sweep_canonical src=%h: got enc=%h lat=%0d expected enc=%h lat=%0d",
                           src, e, lat, xe, int'(xe[11:8]) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
